// File: rtl/up_arb_pkg.sv
// Shared types and constants for the two-master microprocessor bus arbiter.
package up_arb_pkg;

  // Address bit that selects between port 0 and port 1.
  localparam int UP_ADDR_PORT_BIT = 31;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_e;

  // One captured master command, held until the slave completes it.
  typedef struct packed {
    logic        valid;
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
  } up_cmd_t;

endpackage

// File: rtl/up_arb_master_if.sv
// Per-master front end: captures one strobe into a pending command,
// reports it as pending, and holds the data of the last completed read.
module up_arb_master_if
  import up_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic        rd,
  input  logic [31:0] addr,
  input  logic [31:0] data_wr,
  input  logic        done,
  input  logic        rd_load,
  input  logic [31:0] rd_value,
  output up_cmd_t     cmd,
  output logic        pending,
  output logic [31:0] data_rd
);

  // Capture a new command only when nothing is pending; a write wins over a read.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd <= '0;
    end else if (done) begin
      cmd <= '0;
    end else if (!cmd.valid && (wr || rd)) begin
      cmd.valid <= 1'b1;
      cmd.is_wr <= wr;
      cmd.addr  <= addr;
      cmd.data  <= data_wr;
    end
  end

  // Read data is only replaced when a read of this master completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_rd <= '0;
    end else if (rd_load) begin
      data_rd <= rd_value;
    end
  end

  assign pending = cmd.valid;

endmodule

// File: rtl/up_bus_arbiter.sv
// Round-robin arbiter sharing the two ports' register buses between the
// SPI and VJTAG CPU masters. One transaction runs at a time.
// Optional feature: define UP_ARB_TIMEOUT_EN to force-complete a
// transaction after TIMEOUT_CYCLES WAIT cycles and raise sticky to_err.
module up_bus_arbiter
  import up_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic        up_clk,
  input  logic        up_rst,
  input  logic        m0_wr,
  input  logic        m0_rd,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_data_wr,
  output logic [31:0] m0_data_rd,
  output logic        m0_wait,
  input  logic        m1_wr,
  input  logic        m1_rd,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_data_wr,
  output logic [31:0] m1_data_rd,
  output logic        m1_wait,
  output logic        s_cs_p0,
  output logic        s_cs_p1,
  output logic        s_wr,
  output logic        s_rd,
  output logic [31:0] s_addr,
  output logic [31:0] s_data_wr,
  input  logic [31:0] s_data_rd_p0,
  input  logic [31:0] s_data_rd_p1,
  input  logic        s_busy_p0,
  input  logic        s_busy_p1,
  output logic        to_err
);

  if (TIMEOUT_CYCLES < 4 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("up_bus_arbiter: TIMEOUT_CYCLES must be within 4..65535");
  end

  arb_state_e  state, next_state;
  logic        grant, grant_next;
  logic        last_grant;
  up_cmd_t     cmd0, cmd1, gcmd;
  logic        port_sel;
  logic        sel_busy;
  logic [31:0] sel_data;
  logic        done;
  logic        timeout_hit;
  logic [31:0] rd_value;

  up_arb_master_if u_m0 (
    .clk      (up_clk),
    .rst      (up_rst),
    .wr       (m0_wr),
    .rd       (m0_rd),
    .addr     (m0_addr),
    .data_wr  (m0_data_wr),
    .done     (done && !grant),
    .rd_load  (done && !grant && !gcmd.is_wr),
    .rd_value (rd_value),
    .cmd      (cmd0),
    .pending  (m0_wait),
    .data_rd  (m0_data_rd)
  );

  up_arb_master_if u_m1 (
    .clk      (up_clk),
    .rst      (up_rst),
    .wr       (m1_wr),
    .rd       (m1_rd),
    .addr     (m1_addr),
    .data_wr  (m1_data_wr),
    .done     (done && grant),
    .rd_load  (done && grant && !gcmd.is_wr),
    .rd_value (rd_value),
    .cmd      (cmd1),
    .pending  (m1_wait),
    .data_rd  (m1_data_rd)
  );

  assign gcmd     = grant ? cmd1 : cmd0;
  assign port_sel = gcmd.addr[UP_ADDR_PORT_BIT];
  assign sel_busy = port_sel ? s_busy_p1 : s_busy_p0;
  assign sel_data = port_sel ? s_data_rd_p1 : s_data_rd_p0;
  assign rd_value = timeout_hit ? TIMEOUT_DATA : sel_data;

`ifdef UP_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_cnt;
  logic        to_flag;

  assign timeout_hit = (state == WAIT) && sel_busy && (wait_cnt == TIMEOUT_LAST);
  assign to_err      = to_flag;

  // Count WAIT cycles from zero on each entry; latch a timeout until reset.
  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      wait_cnt <= '0;
      to_flag  <= 1'b0;
    end else begin
      if (state == WAIT) begin
        wait_cnt <= wait_cnt + 16'd1;
      end else begin
        wait_cnt <= '0;
      end
      if (timeout_hit) begin
        to_flag <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign to_err      = 1'b0;
`endif

  // State, current grant and the master served last (master 1 so master 0 wins the first tie).
  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= next_state;
      grant <= grant_next;
      if (done) begin
        last_grant <= grant;
      end
    end
  end

  // Next-state, grant choice and slave bus drive from the granted command.
  always_comb begin
    next_state = state;
    grant_next = grant;
    done       = 1'b0;
    s_cs_p0    = 1'b0;
    s_cs_p1    = 1'b0;
    s_wr       = 1'b0;
    s_rd       = 1'b0;
    s_addr     = '0;
    s_data_wr  = '0;
    case (state)
      IDLE: begin
        if (cmd0.valid || cmd1.valid) begin
          next_state = ISSUE;
          if (cmd0.valid && cmd1.valid) begin
            grant_next = ~last_grant;
          end else begin
            grant_next = !cmd0.valid;
          end
        end
      end
      ISSUE: begin
        s_cs_p0    = !port_sel;
        s_cs_p1    = port_sel;
        s_wr       = gcmd.is_wr;
        s_rd       = !gcmd.is_wr;
        s_addr     = {1'b0, gcmd.addr[UP_ADDR_PORT_BIT-1:0]};
        s_data_wr  = gcmd.data;
        next_state = WAIT;
      end
      WAIT: begin
        s_cs_p0   = !port_sel;
        s_cs_p1   = port_sel;
        s_addr    = {1'b0, gcmd.addr[UP_ADDR_PORT_BIT-1:0]};
        s_data_wr = gcmd.data;
        if (!sel_busy || timeout_hit) begin
          done       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_up_bus_arbiter.sv
// Self-checking bench for up_bus_arbiter: a transaction-level model checked
// every cycle, plus directed scenarios with hand-computed expectations.
// Timeout scenarios are built when UP_ARB_TIMEOUT_EN is defined.
module tb_up_bus_arbiter;

  localparam int TO_CYC = 8;
`ifdef UP_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_wr = 0, m0_rd = 0, m1_wr = 0, m1_rd = 0;
  logic [31:0] m0_addr = 0, m0_data_wr = 0, m1_addr = 0, m1_data_wr = 0;
  logic [31:0] m0_data_rd, m1_data_rd;
  logic        m0_wait, m1_wait;
  logic        s_cs_p0, s_cs_p1, s_wr, s_rd;
  logic [31:0] s_addr, s_data_wr;
  logic [31:0] s_data_rd_p0 = 0, s_data_rd_p1 = 0;
  logic        s_busy_p0 = 0, s_busy_p1 = 0;
  logic        to_err;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;
  int rd_pulses = 0;

  up_bus_arbiter #(.TIMEOUT_CYCLES(TO_CYC), .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
    .up_clk(clk), .up_rst(rst),
    .m0_wr(m0_wr), .m0_rd(m0_rd), .m0_addr(m0_addr), .m0_data_wr(m0_data_wr),
    .m0_data_rd(m0_data_rd), .m0_wait(m0_wait),
    .m1_wr(m1_wr), .m1_rd(m1_rd), .m1_addr(m1_addr), .m1_data_wr(m1_data_wr),
    .m1_data_rd(m1_data_rd), .m1_wait(m1_wait),
    .s_cs_p0(s_cs_p0), .s_cs_p1(s_cs_p1), .s_wr(s_wr), .s_rd(s_rd),
    .s_addr(s_addr), .s_data_wr(s_data_wr),
    .s_data_rd_p0(s_data_rd_p0), .s_data_rd_p1(s_data_rd_p1),
    .s_busy_p0(s_busy_p0), .s_busy_p1(s_busy_p1), .to_err(to_err)
  );

  always #5 clk = ~clk;

  // Transaction-level model: pending flag per master, one active transaction
  // described by its owner and its age in cycles since the slave strobe.
  bit          mp[2];
  bit          mw[2];
  logic [31:0] ma[2], md[2], mrd[2];
  int          act;
  int          age;
  int          last;
  bit          mto;

  task automatic modelStep();
    bit old_p[2];
    bit busy;
    bit hit;
    logic [31:0] pdata;
    if (rst) begin
      mp = '{0, 0}; mw = '{0, 0};
      ma = '{0, 0}; md = '{0, 0}; mrd = '{0, 0};
      act = -1; age = 0; last = 1; mto = 0;
      return;
    end
    old_p = mp;
    if (act >= 0) begin
      busy  = ma[act][31] ? s_busy_p1 : s_busy_p0;
      pdata = ma[act][31] ? s_data_rd_p1 : s_data_rd_p0;
      hit   = TO_EN && busy && (age == TO_CYC);
      if (age >= 1 && (!busy || hit)) begin
        if (!mw[act]) mrd[act] = hit ? 32'hDEAD_BEEF : pdata;
        if (hit) mto = 1;
        mp[act] = 0;
        last = act;
        act = -1;
      end else begin
        age++;
      end
    end else if (old_p[0] || old_p[1]) begin
      if (old_p[0] && old_p[1]) act = (last == 1) ? 0 : 1;
      else act = old_p[0] ? 0 : 1;
      age = 0;
    end
    if (!old_p[0] && (m0_wr || m0_rd)) begin
      mp[0] = 1; mw[0] = m0_wr; ma[0] = m0_addr; md[0] = m0_data_wr;
    end
    if (!old_p[1] && (m1_wr || m1_rd)) begin
      mp[1] = 1; mw[1] = m1_wr; ma[1] = m1_addr; md[1] = m1_data_wr;
    end
  endtask

  always @(posedge clk) modelStep();

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareCycle();
    logic [6:0]  exp_ctrl;
    logic [31:0] exp_addr, exp_data;
    exp_ctrl = '0; exp_addr = '0; exp_data = '0;
    if (act >= 0) begin
      exp_ctrl[6] = !ma[act][31];
      exp_ctrl[5] = ma[act][31];
      exp_ctrl[4] = (age == 0) && mw[act];
      exp_ctrl[3] = (age == 0) && !mw[act];
      exp_addr    = {1'b0, ma[act][30:0]};
      exp_data    = md[act];
    end
    exp_ctrl[2] = mp[0];
    exp_ctrl[1] = mp[1];
    exp_ctrl[0] = mto;
    checkOutput("cyc_ctrl", {25'd0, s_cs_p0, s_cs_p1, s_wr, s_rd, m0_wait, m1_wait, to_err},
                {25'd0, exp_ctrl});
    checkOutput("cyc_s_addr", s_addr, exp_addr);
    checkOutput("cyc_s_data_wr", s_data_wr, exp_data);
    checkOutput("cyc_m0_data_rd", m0_data_rd, mrd[0]);
    checkOutput("cyc_m1_data_rd", m1_data_rd, mrd[1]);
  endtask

  always @(negedge clk) begin
    if (chk_en) compareCycle();
    if (s_rd) rd_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(int m, logic wr, logic rd, logic [31:0] a, logic [31:0] d);
    if (m == 0) begin
      m0_wr = wr; m0_rd = rd; m0_addr = a; m0_data_wr = d;
    end else begin
      m1_wr = wr; m1_rd = rd; m1_addr = a; m1_data_wr = d;
    end
  endtask

  task automatic clearStrobes();
    m0_wr = 0; m0_rd = 0; m1_wr = 0; m1_rd = 0;
  endtask

  initial begin
    tick; tick;
    rst = 0;
    chk_en = 1;
    checkOutput("reset_ctrl", {25'd0, s_cs_p0, s_cs_p1, s_wr, s_rd, m0_wait, m1_wait, to_err}, 0);
    checkOutput("reset_m0_data_rd", m0_data_rd, 0);

    // Master 0 write, port 0 never busy
    tick;
    applyStimulus(0, 1, 0, 32'h0000_0010, 32'h1234_5678);
    tick; clearStrobes();
    checkOutput("wr_wait_t1", m0_wait, 1);
    tick;
    checkOutput("wr_issue_ctrl", {s_cs_p0, s_cs_p1, s_wr, s_rd}, 4'b1010);
    checkOutput("wr_issue_addr", s_addr, 32'h0000_0010);
    checkOutput("wr_issue_data", s_data_wr, 32'h1234_5678);
    tick;
    checkOutput("wr_wait_t3", {m0_wait, s_cs_p0, s_wr}, 3'b110);
    tick;
    checkOutput("wr_done_t4", {m0_wait, s_cs_p0}, 2'b00);
    checkOutput("wr_keeps_rd", m0_data_rd, 0);

    // Master 1 read from port 1, busy for 5 WAIT cycles; port 0 busy is ignored
    tick;
    s_busy_p1 = 1; s_busy_p0 = 1; s_data_rd_p1 = 32'hCAFE_0001;
    applyStimulus(1, 0, 1, 32'h8000_0004, 32'h0);
    tick; clearStrobes();
    tick;
    checkOutput("rd1_issue_ctrl", {s_cs_p0, s_cs_p1, s_wr, s_rd}, 4'b0101);
    checkOutput("rd1_issue_addr", s_addr, 32'h0000_0004);
    repeat (5) tick;
    checkOutput("rd1_busy_t7", {m1_wait, s_cs_p1}, 2'b11);
    tick; s_busy_p1 = 0;
    checkOutput("rd1_wait_t8", m1_wait, 1);
    tick;
    checkOutput("rd1_done_t9", m1_wait, 0);
    checkOutput("rd1_data", m1_data_rd, 32'hCAFE_0001);
    s_busy_p0 = 0;

    // Repeated m0_rd strobes while pending are ignored
    tick;
    rd_pulses = 0;
    s_busy_p0 = 1; s_data_rd_p0 = 32'h5555_AAAA;
    applyStimulus(0, 0, 1, 32'h0000_0020, 32'h0);
    tick; clearStrobes();
    applyStimulus(0, 0, 1, 32'h0000_0040, 32'h0);
    tick; clearStrobes();
    checkOutput("dbl_issue_addr", s_addr, 32'h0000_0020);
    tick;
    applyStimulus(0, 0, 1, 32'h0000_0044, 32'h0);
    tick; clearStrobes();
    checkOutput("dbl_wait_addr", s_addr, 32'h0000_0020);
    tick; s_busy_p0 = 0;
    tick;
    checkOutput("dbl_done", m0_wait, 0);
    checkOutput("dbl_data", m0_data_rd, 32'h5555_AAAA);
    tick; tick;
    checkOutput("dbl_no_replay", {m0_wait, s_cs_p0}, 2'b00);
    checkOutput("dbl_rd_pulses", rd_pulses, 1);

    // A write completion leaves the last read data in place
    tick;
    applyStimulus(0, 1, 0, 32'h0000_0030, 32'h0F0F_0F0F);
    tick; clearStrobes();
    repeat (3) tick;
    checkOutput("wr2_done", m0_wait, 0);
    checkOutput("wr2_keeps_rd", m0_data_rd, 32'h5555_AAAA);

`ifdef UP_ARB_TIMEOUT_EN
    // Port 0 stuck busy: forced completion after 8 WAIT cycles
    tick;
    s_busy_p0 = 1; s_data_rd_p0 = 32'h0BAD_F00D;
    applyStimulus(0, 0, 1, 32'h0000_0050, 32'h0);
    tick; clearStrobes();
    repeat (9) tick;
    checkOutput("to_wait_t10", {m0_wait, to_err}, 2'b10);
    tick;
    checkOutput("to_done_t11", m0_wait, 0);
    checkOutput("to_data", m0_data_rd, 32'hDEAD_BEEF);
    checkOutput("to_err_set", to_err, 1);
    repeat (3) tick;
    s_busy_p0 = 0;
    checkOutput("to_err_sticky", to_err, 1);
`else
    // Port 0 busy for a long time: no timeout, completion on release
    tick;
    s_busy_p0 = 1; s_data_rd_p0 = 32'h0BAD_F00D;
    applyStimulus(0, 0, 1, 32'h0000_0050, 32'h0);
    tick; clearStrobes();
    repeat (20) tick;
    checkOutput("long_busy_wait", {m0_wait, to_err}, 2'b10);
    s_busy_p0 = 0;
    tick;
    checkOutput("long_busy_done", m0_wait, 0);
    checkOutput("long_busy_data", m0_data_rd, 32'h0BAD_F00D);
`endif

    // Reset during WAIT abandons the transaction
    tick;
    s_busy_p0 = 1;
    applyStimulus(0, 0, 1, 32'h0000_0060, 32'h0);
    tick; clearStrobes();
    tick; tick; tick;
    checkOutput("rst_in_wait", {s_cs_p0, m0_wait}, 2'b11);
    rst = 1;
    tick; rst = 0;
    rd_pulses = 0;
    checkOutput("rst_ctrl", {25'd0, s_cs_p0, s_cs_p1, s_wr, s_rd, m0_wait, m1_wait, to_err}, 0);
    checkOutput("rst_addr", s_addr, 0);
    checkOutput("rst_m0_data_rd", m0_data_rd, 0);
    tick; tick; tick;
    checkOutput("rst_no_replay", {25'd0, s_cs_p0, s_cs_p1, s_wr, s_rd, m0_wait, m1_wait, to_err}, 0);
    checkOutput("rst_rd_pulses", rd_pulses, 0);
    s_busy_p0 = 0;

    // Simultaneous strobes after reset: master 0 first, then master 1
    tick;
    applyStimulus(0, 1, 0, 32'h0000_0070, 32'h0000_00A0);
    applyStimulus(1, 1, 0, 32'h8000_0074, 32'h0000_00B1);
    tick; clearStrobes();
    checkOutput("tie1_waits", {m0_wait, m1_wait}, 2'b11);
    tick;
    checkOutput("tie1_first", {s_cs_p0, s_cs_p1, s_wr}, 3'b101);
    checkOutput("tie1_first_addr", s_addr, 32'h0000_0070);
    tick; tick;
    checkOutput("tie1_gap", {m0_wait, m1_wait, s_cs_p0, s_cs_p1}, 4'b0100);
    tick;
    checkOutput("tie1_second", {s_cs_p0, s_cs_p1, s_wr}, 3'b011);
    checkOutput("tie1_second_addr", s_addr, 32'h0000_0074);
    checkOutput("tie1_second_data", s_data_wr, 32'h0000_00B1);
    tick; tick;
    checkOutput("tie1_done", {m0_wait, m1_wait}, 2'b00);

    // Second tie: master 1 was served last, so master 0 goes first again
    tick;
    applyStimulus(0, 0, 1, 32'h0000_0078, 32'h0);
    applyStimulus(1, 0, 1, 32'h8000_007C, 32'h0);
    tick; clearStrobes();
    tick;
    checkOutput("tie2_first", {s_cs_p0, s_cs_p1, s_rd}, 3'b101);
    checkOutput("tie2_first_addr", s_addr, 32'h0000_0078);
    tick; tick; tick;
    checkOutput("tie2_second", {s_cs_p0, s_cs_p1, s_rd}, 3'b011);
    checkOutput("tie2_second_addr", s_addr, 32'h0000_007C);
    tick; tick; tick;

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
